// File: rtl/function_checker_pkg.sv
// Shared types and helpers for the function_checker truth-table response checker.
package function_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/function_checker_settle_timer.sv
// Settle timer: counts HOLD cycles from 0 and flags the last one (SETTLE-1).
module settle_timer
  import function_checker_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (clog2(SETTLE) < 1) ? 1 : clog2(SETTLE);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/function_checker.sv
// Sweeps all input vectors into a combinational DUT and checks its output against
// a golden table. Optional macro STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module function_checker
  import function_checker_pkg::*;
#(
  parameter int unsigned                N_IN     = 3,
  parameter logic [(1 << N_IN) - 1:0]   EXPECTED = 8'b11101000,
  parameter int unsigned                SETTLE   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            dut_f,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);

  state_t state, state_next;
  logic   expired;
  logic   mismatch;
  logic   last_vec;
  logic   stop_now;
  logic   timer_clear;

  assign mismatch    = (dut_f != EXPECTED[vec]);
  assign last_vec    = &vec;
  assign timer_clear = (state != S_HOLD);

`ifdef STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_HOLD;
      S_HOLD:   if (expired) state_next = S_SAMPLE;
      S_SAMPLE: state_next = (last_vec || stop_now) ? S_DONE : S_HOLD;
      S_DONE:   if (start) state_next = S_HOLD;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_HOLD) || (state == S_SAMPLE);
    done = (state == S_DONE);
    pass = (state == S_DONE) && (err_count == '0);
  end

  // first_fail is captured while err_count is still zero, i.e. on the first mismatch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec        <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec        <= '0;
            err_count  <= '0;
            first_fail <= '0;
          end
        end
        S_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + (N_IN + 1)'(1);
            if (err_count == '0) first_fail <= vec;
          end
          if (!last_vec && !stop_now) vec <= vec + N_IN'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
